// File: rtl/fifo_rd_prefetch.sv
// Read-side prefetch stage: rempty/rinc pop port to a registered FWFT valid/ready stream.
// Optional FIFO_RD_PARITY_EN adds out_par, even parity carried alongside each word.
module fifo_rd_prefetch #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             rflush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
`ifdef FIFO_RD_PARITY_EN
  output logic             out_par,
`endif
  output logic [1:0]       buf_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic             push, pop;

  // pop request depends on registered state only, never on out_ready
  always_comb begin
    push = ~rrst & ~rempty & ~rflush & (state_q != TWO);
    pop  = out_valid & out_ready;
    rinc = push;
  end

  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q;
  assign buf_cnt   = state_q;

  // next-state and data movement between rdata, skid and head
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (rflush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = rdata;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = rdata;
          end else if (push) begin
            skid_d  = rdata;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // state and data registers
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef FIFO_RD_PARITY_EN
  logic head_par_q, head_par_d;
  logic skid_par_q, skid_par_d;

  // parity follows the same moves as the data words
  always_comb begin
    head_par_d = head_par_q;
    skid_par_d = skid_par_q;
    if (!rflush) begin
      unique case (state_q)
        EMPTY: if (push) head_par_d = ^rdata;
        ONE: begin
          if (push && pop) head_par_d = ^rdata;
          else if (push)   skid_par_d = ^rdata;
        end
        TWO: if (pop) head_par_d = skid_par_q;
        default: ;
      endcase
    end
  end

  // parity registers
  always_ff @(posedge rclk) begin
    if (rrst) begin
      head_par_q <= 1'b0;
      skid_par_q <= 1'b0;
    end else begin
      head_par_q <= head_par_d;
      skid_par_q <= skid_par_d;
    end
  end

  assign out_par = head_par_q;
`endif

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// Directed bench for fifo_rd_prefetch with a small upstream FIFO model.
// Parity checks are built when FIFO_RD_PARITY_EN is defined.
module tb_fifo_rd_prefetch;

  logic       clk = 1'b0;
  logic       rrst, rempty, rinc, rflush;
  logic       out_valid, out_ready;
  logic [7:0] rdata, out_data;
  logic [1:0] buf_cnt;
`ifdef FIFO_RD_PARITY_EN
  logic       out_par;
`endif

  int cmp = 0;
  int err = 0;

  logic [7:0] mem [0:63];
  int         rp = 0;
  int         wp = 0;

  always #5 clk = ~clk;

  // upstream read pointer: advances on every accepted pop
  always @(posedge clk) if (rinc) rp <= rp + 1;

  assign rdata  = mem[rp];
  assign rempty = (rp >= wp);

  fifo_rd_prefetch #(.DSIZE(8)) dut (
    .rclk      (clk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .rflush    (rflush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FIFO_RD_PARITY_EN
    .out_par   (out_par),
`endif
    .buf_cnt   (buf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    wp        = 16;
    rrst      = 1'b1;
    rflush    = 1'b0;
    out_ready = 1'b1;

    // 1 reset with data available
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_rinc", rinc, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_cnt", buf_cnt, 0);
      chk("rst_data", out_data, 0);
    end

    // 2 streaming 0x01..0x10
    rrst = 1'b0;
    #1;
    chk("s_rinc0", rinc, 1);
    chk("s_valid0", out_valid, 0);
    step();
    for (int i = 0; i < 16; i++) begin
      chk("s_valid", out_valid, 1);
      chk("s_data", out_data, 32'(i + 1));
      chk("s_cnt", buf_cnt, 1);
      step();
    end
    chk("s_end_valid", out_valid, 0);
    chk("s_end_cnt", buf_cnt, 0);

    // 3 backpressure
    out_ready = 1'b0;
    mem[16] = 8'hA5; mem[17] = 8'h5A; mem[18] = 8'hC3;
    wp = 19;
    #1;
    chk("b_rinc0", rinc, 1);
    step();
    chk("b_cnt1", buf_cnt, 1);
    chk("b_data1", out_data, 8'hA5);
    chk("b_rinc1", rinc, 1);
    step();
    chk("b_cnt2", buf_cnt, 2);
    chk("b_rinc2", rinc, 0);
    chk("b_rempty2", rempty, 0);
    step();
    chk("b_hold_data", out_data, 8'hA5);
    chk("b_hold_cnt", buf_cnt, 2);
    out_ready = 1'b1;
    #1;
    chk("b_out_a5", out_data, 8'hA5);
    step();
    chk("b_out_5a", out_data, 8'h5A);
    chk("b_out_5a_v", out_valid, 1);
    chk("b_rinc3", rinc, 1);
    step();
    chk("b_out_c3", out_data, 8'hC3);
    step();
    chk("b_end_valid", out_valid, 0);

    // 4 single word then empty
    mem[19] = 8'h33;
    wp = 20;
    #1;
    chk("e_rinc0", rinc, 1);
    step();
    chk("e_rinc1", rinc, 0);
    chk("e_valid1", out_valid, 1);
    chk("e_data1", out_data, 8'h33);
    step();
    chk("e_valid2", out_valid, 0);
    step();
    chk("e_valid3", out_valid, 0);
    chk("e_cnt3", buf_cnt, 0);

    // 5 flush from TWO
    out_ready = 1'b0;
    mem[20] = 8'h11; mem[21] = 8'h22; mem[22] = 8'h44;
    wp = 23;
    step();
    step();
    chk("f_cnt2", buf_cnt, 2);
    rflush = 1'b1;
    #1;
    chk("f_rinc", rinc, 0);
    step();
    rflush = 1'b0;
    chk("f_valid", out_valid, 0);
    chk("f_cnt", buf_cnt, 0);
    out_ready = 1'b1;
    #1;
    chk("f_rinc_after", rinc, 1);
    step();
    chk("f_next_valid", out_valid, 1);
    chk("f_next_data", out_data, 8'h44);
    step();
    chk("f_end_valid", out_valid, 0);

    // reset mid-stream discards buffered word
    out_ready = 1'b0;
    mem[23] = 8'h55; mem[24] = 8'h66;
    wp = 25;
    step();
    chk("r_valid_pre", out_valid, 1);
    chk("r_data_pre", out_data, 8'h55);
    rrst = 1'b1;
    #1;
    chk("r_rinc_gated", rinc, 0);
    step();
    chk("r_valid", out_valid, 0);
    chk("r_data", out_data, 0);
    chk("r_cnt", buf_cnt, 0);

    // stream continues after reset, parity words 0x07, 0x03
    rrst = 1'b0;
    out_ready = 1'b1;
    mem[25] = 8'h07; mem[26] = 8'h03;
    wp = 27;
    step();
    chk("p_data66", out_data, 8'h66);
    step();
    chk("p_data07", out_data, 8'h07);
`ifdef FIFO_RD_PARITY_EN
    chk("p_par07", out_par, 1);
`endif
    step();
    chk("p_data03", out_data, 8'h03);
`ifdef FIFO_RD_PARITY_EN
    chk("p_par03", out_par, 0);
`endif
    step();
    chk("p_end_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
